scarv_cpu_cop_issue: RTL
========================

Name: scarv_cpu_cop_issue

Overview:
- CPU-side initiator for the coprocessor instruction interface.
- Accepts one ISE instruction at a time from the host execute stage and drives the request/ack handshake into the coprocessor.
- Waits for the coprocessor's finish, captures the GPR writeback and result code, and returns them to the host writeback stage.
- Handles pipeline flush and a watchdog timeout. One instruction outstanding at most.

Parameters:
TIMEOUT_CYCLES, 1024, cycles allowed between issue and finish before abandoning; 0 disables the watchdog.
TO_W, 16, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
g_clk  input  1  clock; all state updates on rising edge.
g_resetn  input  1  asynchronous active-low reset.
ex_valid  input  1  host offers an ISE instruction.
ex_ready  output  1  issuer accepts; handshake completes when ex_valid&&ex_ready.
ex_insn  input  32  encoded instruction.
ex_rs1  input  32  GPR rs1 value.
flush  input  1  host kills the in-flight instruction.
wb_valid  output  1  result available to host.
wb_ready  input  1  host consumes result.
wb_rd_wen  output  1  write GPR.
wb_rd  output  5  GPR destination.
wb_wdata  output  32  GPR write data.
wb_result  output  3  coprocessor result code; 0 means success.
wb_exception  output  1  wb_result != 0.
cpu_insn_req  output  1  request to coprocessor.
cop_insn_ack  input  1  coprocessor accepted the request.
cpu_insn_enc  output  32  registered instruction.
cpu_rs1  output  32  registered rs1.
cop_insn_finish  input  1  coprocessor completed.
cpu_insn_ack  output  1  issuer accepts finish.
cop_wen, cop_waddr[4:0], cop_wdata[31:0], cop_result[2:0]  input  finish payload, valid with cop_insn_finish.
busy  output  1  state != IDLE.
stray_finish  output  1  one-cycle pulse when a finish is discarded after timeout.

Behaviour:
- Reset: state IDLE. All outputs 0 except ex_ready=1. Registers cleared; watchdog 0. Reset mid-operation abandons everything with no further handshakes.
- States: IDLE, REQ, WAIT, RSP, DRAIN.
- IDLE:
  - ex_ready=1.
  - On accept: latch ex_insn→cpu_insn_enc, ex_rs1→cpu_rs1, go REQ. cpu_insn_req rises the next cycle.
  - flush is ignored in IDLE.
- REQ:
  - cpu_insn_req=1; enc/rs1 held stable until cop_insn_ack.
  - ack without finish: go WAIT.
  - ack with finish in the same cycle: capture payload, assert cpu_insn_ack, go RSP.
- WAIT:
  - cpu_insn_req=0.
  - cop_insn_finish: cpu_insn_ack=1 combinationally in the same cycle; capture payload; go RSP.
- RSP:
  - wb_valid=1 with the captured payload, held stable until wb_ready.
  - On wb_ready: go IDLE. A new ex accept is possible the following cycle (ex_ready only in IDLE).
- Payload:
  - wb_rd_wen = captured cop_wen && captured result==0.
  - wb_rd=cop_waddr; wb_wdata=cop_wdata; wb_exception=|wb_result.
- Flush:
  - In REQ: request stays asserted until ack (the handshake is never withdrawn). A kill flag is set; go to WAIT as normal.
  - In WAIT: sets the kill flag.
  - When finish arrives with the kill flag set: acked and discarded; go IDLE, no wb_valid.
  - In RSP: wb_valid drops next cycle; go IDLE.
  - flush coincident with finish in WAIT: finish acked, discarded, IDLE.
- Watchdog:
  - Counter clears on accept and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES with no finish that cycle: go RSP with wb_result=3'b111, wb_exception=1, wb_rd_wen=0, wb_wdata=0.
  - If still in REQ at timeout: cpu_insn_req drops.
  - The next state after a timeout-RSP is DRAIN, not IDLE.
- DRAIN:
  - ex_ready=0 until a late finish is seen (acked, stray_finish pulses), then IDLE.
  - If the request was never acked, DRAIN exits to IDLE immediately.
- Watchdog boundaries:
  - A finish arriving in the same cycle the count hits the limit wins; it is a normal completion.
  - With TIMEOUT_CYCLES=0 the issuer waits forever.
- Counter saturates; never wraps.

Test Plan:
- Basic issue: accept insn 0x0000_102B, rs1 0x1234; coprocessor acks at cycle 2 and finishes at cycle 5 with wen=1, waddr=7, wdata=0xDEADBEEF, result=0. Expect req cycles 1–2, cpu_insn_ack at cycle 5, wb_valid at cycle 6 with rd=7, wen=1; IDLE after wb_ready.
- Same-cycle ack+finish: both asserted at cycle 1 with result=3. Expect wb_valid at cycle 2, wb_exception=1, wb_rd_wen=0 even though cop_wen=1.
- Backpressure: wb_ready held low for 4 cycles. Expect wb_valid and payload stable, ex_ready=0 throughout, IDLE one cycle after wb_ready.
- Flush in WAIT, then finish 3 cycles later. Expect cpu_insn_ack on finish, no wb_valid, ex_ready=1 next cycle. Flush in RSP: wb_valid drops next cycle.
- Timeout with TIMEOUT_CYCLES=8: ack without finish. Expect wb_result=7 at count 8; DRAIN after wb_ready; a finish at cycle 20 is acked, stray_finish pulses, then IDLE.
- Reset asserted while in WAIT. Expect immediate req/wb_valid/cpu_insn_ack=0, ex_ready=1 after release.

Source files
------------

// File: rtl/scarv_cpu_cop_issue.sv
// CPU-side issuer for the coprocessor instruction interface: one ISE instruction
// in flight, request/ack into the coprocessor, finish capture, flush and watchdog.
module scarv_cpu_cop_issue #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_insn,
  input  logic [31:0] ex_rs1,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_rd_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wdata,
  output logic [2:0]  wb_result,
  output logic        wb_exception,
  output logic        cpu_insn_req,
  input  logic        cop_insn_ack,
  output logic [31:0] cpu_insn_enc,
  output logic [31:0] cpu_rs1,
  input  logic        cop_insn_finish,
  output logic        cpu_insn_ack,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_result,
  output logic        busy,
  output logic        stray_finish
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RSP, S_DRAIN} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [31:0]     enc_q, enc_d;
  logic [31:0]     rs1_q, rs1_d;
  logic            kill_q, kill_d;
  logic            acked_q, acked_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      res_q, res_d;

  logic [TO_W-1:0] wd_inc;
  logic            wd_hit;
  logic            kill_now;

  // Saturating watchdog; a zero limit never fires.
  assign wd_inc   = (&wd_q) ? wd_q : wd_q + 1'b1;
  assign wd_hit   = (TIMEOUT_CYCLES != 0) && (wd_inc >= TO_LIM);
  assign kill_now = kill_q | flush;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      enc_q   <= '0;
      rs1_q   <= '0;
      kill_q  <= 1'b0;
      acked_q <= 1'b0;
      to_q    <= 1'b0;
      wd_q    <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      rs1_q   <= rs1_d;
      kill_q  <= kill_d;
      acked_q <= acked_d;
      to_q    <= to_d;
      wd_q    <= wd_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    rs1_d   = rs1_q;
    kill_d  = kill_q;
    acked_d = acked_q;
    to_d    = to_q;
    wd_d    = wd_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          enc_d   = ex_insn;
          rs1_d   = ex_rs1;
          kill_d  = 1'b0;
          acked_d = 1'b0;
          to_d    = 1'b0;
          wd_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        wd_d = wd_inc;
        if (flush) kill_d = 1'b1;
        if (state_q == S_REQ && cop_insn_ack) acked_d = 1'b1;
        // A finish in the limit cycle beats the watchdog.
        if (cop_insn_finish && (state_q == S_WAIT || cop_insn_ack)) begin
          if (kill_now) begin
            state_d = S_IDLE;
          end else begin
            wen_d   = cop_wen;
            waddr_d = cop_waddr;
            wdata_d = cop_wdata;
            res_d   = cop_result;
            state_d = S_RSP;
          end
        end else if (wd_hit) begin
          if (kill_now) begin
            state_d = S_DRAIN;
          end else begin
            wen_d   = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            res_d   = 3'b111;
            to_d    = 1'b1;
            state_d = S_RSP;
          end
        end else if (state_q == S_REQ && cop_insn_ack) begin
          state_d = S_WAIT;
        end
      end
      S_RSP: begin
        if (flush || wb_ready) state_d = to_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!acked_q || cop_insn_finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    cpu_insn_req = (state_q == S_REQ);
    wb_valid     = (state_q == S_RSP);
    stray_finish = (state_q == S_DRAIN) && acked_q && cop_insn_finish;
    cpu_insn_ack = ((state_q == S_REQ) && cop_insn_ack && cop_insn_finish) ||
                   ((state_q == S_WAIT) && cop_insn_finish) ||
                   stray_finish;
    cpu_insn_enc = enc_q;
    cpu_rs1      = rs1_q;
    wb_rd_wen    = wen_q && (res_q == 3'd0);
    wb_rd        = waddr_q;
    wb_wdata     = wdata_q;
    wb_result    = res_q;
    wb_exception = |res_q;
  end

endmodule
